// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter reporting sig_in frequency per GATE_CYCLES window
// Optional 2-flop input synchronizer selected by defining FREQ_METER_SYNC_EN.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_WIDTH   = 27
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] freq_out,
    output logic                 valid,
    output logic                 ovf,
    output logic                 busy
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, ALIGN, GATE, REPORT} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
    logic [CNT_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_WIDTH-1:0]   freq_q, freq_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic                   busy_q;
    logic                   sig_prev_q;
    logic                   sig_c;
    logic                   sig_edge;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   sat_next;

`ifdef FREQ_METER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign sig_c = sync2_q;
`else
    assign sig_c = sig_in;
`endif

    assign sig_edge = sig_c & ~sig_prev_q;

    // Saturating increment; the flag records that an edge was lost at full scale.
    always_comb begin
        cnt_next = edge_cnt_q;
        sat_next = sat_q;
        if (sig_edge) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = edge_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (!en) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                end else if (sig_edge) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    state_d    = REPORT;
                    gate_cnt_d = '0;
                    freq_d     = '0;
                    ovf_d      = 1'b0;
                    valid_d    = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                end
            end
            GATE: begin
                if (!en) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    // Latch including an edge on the final gate cycle, then clear for the next gate.
                    state_d    = REPORT;
                    freq_d     = cnt_next;
                    ovf_d      = sat_next;
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                    edge_cnt_d = cnt_next;
                    sat_d      = sat_next;
                end
            end
            REPORT: begin
                state_d = en ? GATE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            sig_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= (state_d != IDLE);
            sig_prev_q <= sig_c;
        end
    end

    assign freq_out = freq_q;
    assign valid    = valid_q;
    assign ovf      = ovf_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed checks of freq_meter with 100-cycle gates at 8- and 5-bit count widths
module tb_freq_meter;

`ifdef FREQ_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int G = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       en8;
    logic       en5;
    logic       sig;
    logic [7:0] freq8;
    logic       valid8, ovf8, busy8;
    logic [4:0] freq5;
    logic       valid5, ovf5, busy5;

    int per = 0;
    int ph = 0;
    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(8)) dut8 (
        .clk_in(clk), .rst(rst), .en(en8), .sig_in(sig),
        .freq_out(freq8), .valid(valid8), .ovf(ovf8), .busy(busy8)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(5)) dut5 (
        .clk_in(clk), .rst(rst), .en(en5), .sig_in(sig),
        .freq_out(freq5), .valid(valid5), .ovf(ovf5), .busy(busy5)
    );

    // Square-wave source, synchronous to clk; per==0 leaves sig under manual control.
    always @(posedge clk) begin
        #1;
        if (per > 0) begin
            sig = (ph < per / 2);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic wait_valid(input bit use5, input int budget, output int cnt);
        cnt = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((use5 ? valid5 : valid8) === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en8 = 1'b0;
        en5 = 1'b0;
        sig = 1'b0;
        step(3);
        chk("reset_freq", 32'(freq8), 0);
        chk("reset_valid", 32'(valid8), 0);
        chk("reset_ovf", 32'(ovf8), 0);
        chk("reset_busy", 32'(busy8), 0);
        rst = 1'b0;

        // ALIGN timeout with sig_in held low
        en8 = 1'b1;
        step(1);
        chk("busy_after_en", 32'(busy8), 1);
        wait_valid(1'b0, 300, n);
        chk("timeout_delay", n, G);
        chk("timeout_freq", 32'(freq8), 0);
        chk("timeout_ovf", 32'(ovf8), 0);
        en8 = 1'b0;
        step(1);
        chk("valid_one_cycle", 32'(valid8), 0);
        chk("busy_idle", 32'(busy8), 0);

        // Single rising edge: report time from the rise shows the input latency
        step(2);
        en8 = 1'b1;
        step(20);
        sig = 1'b1;
        wait_valid(1'b0, 300, n);
        chk("edge_latency", n, G + LAT);
        chk("single_edge_freq", 32'(freq8), 0);
        en8 = 1'b0;
        sig = 1'b0;
        step(3);

        // Continuous measurement of period 10
        per = 10;
        en8 = 1'b1;
        wait_valid(1'b0, 400, n);
        chk("p10_first_seen", 32'(n > 0), 1);
        chk("p10_first_freq", 32'(freq8), 10);
        chk("p10_first_ovf", 32'(ovf8), 0);
        wait_valid(1'b0, 200, n);
        chk("p10_interval", n, G + 1);
        chk("p10_second_freq", 32'(freq8), 10);

        // Drop en mid-gate: measurement discarded
        step(50);
        en8 = 1'b0;
        step(1);
        chk("abort_busy", 32'(busy8), 0);
        wait_valid(1'b0, 150, n);
        chk("abort_no_valid", n, -1);
        chk("abort_freq_held", 32'(freq8), 10);

        // Reset mid-gate, then restart with en still high
        en8 = 1'b1;
        wait_valid(1'b0, 400, n);
        chk("pre_rst_freq", 32'(freq8), 10);
        step(40);
        rst = 1'b1;
        step(1);
        chk("rst_freq", 32'(freq8), 0);
        chk("rst_valid", 32'(valid8), 0);
        chk("rst_ovf", 32'(ovf8), 0);
        chk("rst_busy", 32'(busy8), 0);
        rst = 1'b0;
        step(1);
        chk("restart_busy", 32'(busy8), 1);
        wait_valid(1'b0, 400, n);
        chk("restart_seen", 32'(n > 0), 1);
        chk("restart_freq", 32'(freq8), 10);
        en8 = 1'b0;

        // 5-bit counter saturation at period 2, then recovery at period 10
        per = 2;
        en5 = 1'b1;
        wait_valid(1'b1, 400, n);
        chk("sat_seen", 32'(n > 0), 1);
        chk("sat_freq", 32'(freq5), 31);
        chk("sat_ovf", 32'(ovf5), 1);
        per = 10;
        wait_valid(1'b1, 200, n);
        chk("transition_seen", 32'(n > 0), 1);
        wait_valid(1'b1, 200, n);
        chk("recover_interval", n, G + 1);
        chk("recover_freq", 32'(freq5), 10);
        chk("recover_ovf", 32'(ovf5), 0);
        en5 = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of an external square-wave `sig_in` by counting its rising edges over a gate window of `GATE_CYCLES` `clk_in` periods. With the 100 MHz board clock and the default gate, the gate is exactly 1 s, so the result reads directly in Hz. It is the measuring end of the team's clock dividers, used to check divider outputs and external oscillators on the board. Results are presented with a one-cycle valid pulse for downstream 7-segment or LED display logic.

## Interface
- `GATE_CYCLES`, default 100000000: gate length in `clk_in` cycles; also the ALIGN timeout; must be ≥ 2.
- `CNT_WIDTH`, default 27: width of the edge counter and of `freq_out`.
- `clk_in`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  measurement enable, level-sensitive, synchronous to `clk_in`.
- `sig_in`  input  1  signal under measurement; asynchronous when `FREQ_METER_SYNC_EN` is defined.
- `freq_out`  output  CNT_WIDTH  last reported edge count; holds its value between reports.
- `valid`  output  1  one-cycle pulse when `freq_out`/`ovf` are updated.
- `ovf`  output  1  the last report saturated; updated together with `freq_out`.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- Edge detect: `edge` = (conditioned `sig_in`) AND NOT (its value one cycle earlier).
- States:
  - IDLE: `busy`=0. If `en`=1, go to ALIGN.
  - ALIGN: waits for the first `edge`, so the gate starts phase-aligned to the signal.
    - `edge` seen: go to GATE. This aligning edge is not counted.
    - No edge within `GATE_CYCLES` cycles: go to REPORT with count 0.
  - GATE: runs exactly `GATE_CYCLES` cycles, tracked by a gate counter 0..GATE_CYCLES-1.
    - The edge counter increments on every cycle with `edge`=1, including the last gate cycle.
    - After gate count GATE_CYCLES-1, go to REPORT.
  - REPORT: lasts one cycle.
    - `freq_out` ← edge count, `ovf` ← saturation flag, `valid`=1.
    - Edge and gate counters clear.
    - Next state: GATE if `en`=1 (back-to-back gates, no realignment); IDLE otherwise.
    - Edges occurring during the REPORT cycle are not counted.
- Saturation: the edge counter stops at 2^CNT_WIDTH−1 and sets an internal saturation flag. The flag clears when the counters clear.
- `en`=0 in ALIGN or GATE: next state is IDLE. The measurement is discarded, with no `valid` pulse, and `freq_out`/`ovf` keep their previous values.
- `rst`=1 (in any state, including mid-gate) has priority over all other inputs. On the next edge:
  - state → IDLE;
  - all counters = 0;
  - `freq_out`=0, `valid`=0, `ovf`=0, `busy`=0.

## Timing
- All outputs are registered; `valid`, `freq_out` and `ovf` change on the same clock edge.
- `valid` rises on the clock edge that follows the last GATE cycle and is high for exactly 1 cycle.
- `en` rises → ALIGN on the next edge (`busy`=1 one cycle after `en` is sampled high).
- First report after alignment: ALIGN exit + `GATE_CYCLES` + 1 cycles.
- Continuous mode: one report every `GATE_CYCLES`+1 cycles.
- `sig_in` rising edge → counted edge: 3 `clk_in` edges with the macro, 1 edge without it.
- Maximum countable rate: one edge per 2 `clk_in` cycles (`sig_in` high and low each ≥ 1 cycle after conditioning).

## Configuration
- `FREQ_METER_SYNC_EN` defined: `sig_in` passes through a 2-flop synchronizer before edge detection.
  - Edge latency is 3 cycles.
  - `sig_in` may be fully asynchronous.
- Not defined: no synchronizer.
  - `sig_in` must be synchronous to `clk_in`.
  - Edge latency is 1 cycle.
- Counts, state behaviour and report timing relative to the conditioned signal are identical in both builds.

## Test plan
All scenarios use `GATE_CYCLES`=100, `CNT_WIDTH`=8, and the macro defined unless stated otherwise.
- `sig_in` with period 10 cycles, `en`=1 held → every report has `freq_out`=10, `ovf`=0; `valid` pulses are 101 cycles apart.
- `sig_in` held at 0, `en`=1 → `valid` after the 100-cycle ALIGN timeout with `freq_out`=0, `ovf`=0.
- `CNT_WIDTH`=5, `sig_in` with period 2 (50 edges per gate) → `freq_out`=31, `ovf`=1. A following gate at period 10 gives `freq_out`=10, `ovf`=0.
- Complete one report of 10, then drop `en` at gate cycle 50 of the next gate → no `valid`; `busy`=0 on the next cycle; `freq_out` stays 10.
- Assert `rst` for 1 cycle at gate cycle 40 → next cycle: all outputs 0, `busy`=0. With `en` still high, measurement restarts from ALIGN.
- Without the macro, synchronous `sig_in` with period 4 → `freq_out`=25. The first counted edge updates the counter 1 cycle after the `sig_in` rise, checked against the macro build's 3 cycles.
